// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, channel-select width helper and the staged channel config type.
`default_nettype none

package clk_div_pkg;

  localparam int HALF_W   = 24;
  localparam int DEF_HALF = 25000;

  typedef struct packed {
    logic [HALF_W-1:0] half;
    logic              en;
  } ch_cfg_t;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with staged reconfiguration applied only at a full-period boundary.
`default_nettype none

module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = HALF_W,
  parameter int DEF_HALF = clk_div_pkg::DEF_HALF
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    sync,
  input  logic    we,
  input  ch_cfg_t wr_cfg,
  output logic    pend,
  output logic    clk_out,
  output logic    tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] eff_half;
  logic             en;
  ch_cfg_t          stg;
  logic             wrap;
  logic             apply;

  // half of 0 behaves like 1 so the channel never stalls
  assign eff_half = (half == '0) ? CNT_W'(1) : half;
  assign wrap     = (cnt == eff_half - CNT_W'(1));
  // an enabled channel only reconfigures on its 1->0 wrap, so no short pulse is ever emitted
  assign apply    = pend && (sync || !en || (wrap && clk_out));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      half    <= CNT_W'(DEF_HALF);
      en      <= 1'b1;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pend    <= 1'b0;
      stg     <= '0;
    end else begin
      if (we) begin
        stg  <= wr_cfg;
        pend <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end

      if (sync || apply) begin
        if (apply) begin
          half <= CNT_W'(stg.half);
          en   <= stg.en;
        end
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (!en) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (wrap) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_div_multi.sv
// clk_div_multi: N-channel runtime-programmable clock divider; define CLK_DIV_SYNC_EN to add the
// sync_in port that restarts all channels phase-aligned.
`default_nettype none

module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int N_CH     = 4,
  parameter int CNT_W    = HALF_W,
  parameter int DEF_HALF = clk_div_pkg::DEF_HALF
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
`ifdef CLK_DIV_SYNC_EN
  input  logic                    sync_in,
`endif
  input  logic                    cfg_we,
  input  logic [ch_w(N_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]        cfg_half,
  input  logic                    cfg_en,
  output logic [N_CH-1:0]         cfg_pend,
  output logic [N_CH-1:0]         clk_out,
  output logic [N_CH-1:0]         tick
);

  localparam int CH_W = ch_w(N_CH);

  logic    sync;
  ch_cfg_t wr_cfg;

`ifdef CLK_DIV_SYNC_EN
  assign sync = sync_in;
`else
  assign sync = 1'b0;
`endif

  // staging type holds HALF_W bits; CNT_W is expected not to exceed it
  assign wr_cfg = '{half: HALF_W'(cfg_half), en: cfg_en};

  // out-of-range cfg_ch matches no channel, so such writes are dropped
  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    localparam logic [CH_W-1:0] IDX = CH_W'(i);

    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_HALF(DEF_HALF)
    ) u_chan (
      .clk    (clk_in),
      .rst    (rst_in),
      .sync   (sync),
      .we     (cfg_we && (cfg_ch == IDX)),
      .wr_cfg (wr_cfg),
      .pend   (cfg_pend[i]),
      .clk_out(clk_out[i]),
      .tick   (tick[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed and random config writes checked each cycle against a phase-position model.
`default_nettype none

module tb_clk_div_multi;

  localparam int N_CH     = 3;
  localparam int CNT_W    = 24;
  localparam int DEF_HALF = 20;
  localparam int CH_W     = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sync = 1'b0;
  logic             we = 1'b0;
  logic [CH_W-1:0]  ch = '0;
  logic [CNT_W-1:0] half_in = '0;
  logic             en_in = 1'b0;
  logic [N_CH-1:0]  pend, clk_o, tick_o;

  always #5 clk = ~clk;

  clk_div_multi #(
    .CLK_HZ  (50_000_000),
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .DEF_HALF(DEF_HALF)
  ) dut (
    .clk_in  (clk),
    .rst_in  (rst),
`ifdef CLK_DIV_SYNC_EN
    .sync_in (sync),
`endif
    .cfg_we  (we),
    .cfg_ch  (ch),
    .cfg_half(half_in),
    .cfg_en  (en_in),
    .cfg_pend(pend),
    .clk_out (clk_o),
    .tick    (tick_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // model: each channel tracks its position t inside the current period of 2*eh cycles
  int unsigned m_t[N_CH];
  int unsigned m_half[N_CH];
  bit          m_en[N_CH];
  bit          m_pend[N_CH];
  int unsigned s_half[N_CH];
  bit          s_en[N_CH];

  function automatic int unsigned eh(input int c);
    return (m_half[c] == 0) ? 1 : m_half[c];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_t[c] = 0; m_half[c] = DEF_HALF; m_en[c] = 1; m_pend[c] = 0;
      s_half[c] = 0; s_en[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < N_CH; c++) begin
      bit w = we && (int'(ch) == c);
      bit boundary = m_en[c] ? (m_t[c] == 2 * eh(c) - 1) : 1'b1;
      if (sync || (m_pend[c] && boundary)) begin
        if (m_pend[c]) begin
          m_half[c] = s_half[c];
          m_en[c]   = s_en[c];
        end
        m_t[c] = 0;
        m_pend[c] = w;
      end else begin
        m_t[c] = m_en[c] ? (m_t[c] + 1) % (2 * eh(c)) : 0;
        if (w) m_pend[c] = 1;
      end
      if (w) begin
        s_half[c] = int'(half_in);
        s_en[c]   = en_in;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N_CH-1:0] ec, et, ep;
    for (int c = 0; c < N_CH; c++) begin
      ec[c] = m_en[c] && (m_t[c] >= eh(c));
      et[c] = m_en[c] && (m_t[c] == eh(c));
      ep[c] = m_pend[c];
    end
    check_val({tag, "_clk"}, 32'(clk_o), 32'(ec));
    check_val({tag, "_tick"}, 32'(tick_o), 32'(et));
    check_val({tag, "_pend"}, 32'(pend), 32'(ep));
  endtask

  task automatic cyc(input bit w, input int c, input int h, input bit e);
    we = w;
    ch = c[CH_W-1:0];
    half_in = h[CNT_W-1:0];
    en_in = e;
    @(posedge clk);
    model_step();
    #1;
    check_outputs("cyc");
    we = 1'b0;
    sync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic mid_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check_val({tag, "_clk"}, 32'(clk_o), 0);
    check_val({tag, "_tick"}, 32'(tick_o), 0);
    check_val({tag, "_pend"}, 32'(pend), 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int ticks;
    bit hit;
    model_reset();
    #12;
    check_val("reset_clk", 32'(clk_o), 0);
    check_val("reset_tick", 32'(tick_o), 0);
    check_val("reset_pend", 32'(pend), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // default divider: two ticks per channel over two default periods
    ticks = 0;
    for (int i = 0; i < 4 * DEF_HALF; i++) begin
      cyc(0, 0, 0, 0);
      ticks += int'(tick_o[0]);
    end
    check_val("default_tick_count", 32'(ticks), 2);

    // staged mid-period change on ch1
    idle(7);
    cyc(1, 1, 3, 1);
    check_val("ch1_staged", 32'(pend[1]), 1);
    idle(60);

    // disable ch2, then re-enable at half=0
    cyc(1, 2, 9, 0);
    idle(50);
    cyc(1, 2, 0, 1);
    idle(10);

    // out-of-range channel write
    cyc(1, 3, 5, 1);
    check_val("oob_pend", 32'(pend), 0);
    idle(5);

    // last write wins
    cyc(1, 0, 5, 1);
    cyc(1, 0, 7, 1);
    idle(60);

    // async reset during a high phase with a write staged
    cyc(1, 0, 9, 1);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc(0, 0, 0, 0);
      hit = clk_o[0];
    end
    check_val("wait_high", 32'(hit), 1);
    mid_reset("async_rst");
    idle(2 * DEF_HALF + 5);

`ifdef CLK_DIV_SYNC_EN
    cyc(1, 1, 2, 1);
    idle(3);
    sync = 1'b1;
    cyc(0, 0, 0, 0);
    check_val("sync_clk", 32'(clk_o), 0);
    idle(30);
`endif

    // random reconfiguration traffic
    for (int i = 0; i < 3000; i++) begin
`ifdef CLK_DIV_SYNC_EN
      sync = ($urandom_range(0, 63) == 0);
`endif
      if ($urandom_range(0, 7) == 0)
        cyc(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), $urandom_range(0, 3) != 0);
      else
        cyc(0, 0, 0, 0);
      if (i == 1500) mid_reset("rand_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
